// File: rtl/miner_pkg.sv
// Shared types for the mining datapath: nonce width and the buffered
// winning-nonce entry tagged with its block epoch.
package miner_pkg;

    localparam int unsigned NONCE_W = 32;

    typedef logic [NONCE_W-1:0] nonce_t;

    typedef struct packed {
        nonce_t nonce;
        logic   epoch;
    } nonce_entry_t;

    localparam int unsigned ENTRY_W = $bits(nonce_entry_t);

endpackage

// File: rtl/nonce_fifo.sv
// Show-ahead FIFO with occupancy count; the head word reads as zero while empty
// so the uninitialised storage array never reaches the outputs.
module nonce_fifo #(
    parameter int unsigned LogDepth = 3,
    parameter int unsigned Width    = 33
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [Width-1:0]    wdata_i,
    input  logic                pop_i,
    output logic [Width-1:0]    rdata_o,
    output logic                full_o,
    output logic                empty_o,
    output logic [LogDepth:0]   count_o
);

    localparam int unsigned Depth = 2 ** LogDepth;
    localparam logic [LogDepth:0] FullCount = (LogDepth + 1)'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [LogDepth-1:0] wr_ptr_q, wr_ptr_d;
    logic [LogDepth-1:0] rd_ptr_q, rd_ptr_d;
    logic [LogDepth:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + LogDepth'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + LogDepth'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + (LogDepth + 1)'(1);
            2'b01:   count_d = count_q - (LogDepth + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FullCount);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/nonce_collector.sv
// Tracks the nonce of each hash-validator result, buffers winning nonces with
// their block epoch, and flags (sticky) any winner dropped on a full buffer.
module nonce_collector
    import miner_pkg::*;
#(
    parameter int unsigned LOGDEPTH  = 3,
    parameter int unsigned NONCEBITS = NONCE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 resultValid,
    input  logic                 newBlock,
    input  logic                 success,
    input  logic                 rdReq,
    input  logic                 clrOverflow,
    output logic                 rdValid,
    output logic [NONCEBITS-1:0] rdNonce,
    output logic                 rdEpoch,
    output logic [LOGDEPTH:0]    count,
    output logic                 overflow
);

    logic [NONCEBITS-1:0] next_nonce_q, next_nonce_d;
    logic                 epoch_q, epoch_d;
    logic                 overflow_q, overflow_d;

    logic [NONCEBITS-1:0] result_nonce;
    logic                 result_epoch;
    logic                 win, push, pop, drop;
    logic                 fifo_full, fifo_empty;
    logic [NONCEBITS:0]   fifo_rdata;

    // A newBlock result is nonce 0 of the next block and opens a new epoch.
    always_comb begin
        next_nonce_d = next_nonce_q;
        epoch_d      = epoch_q;
        result_nonce = next_nonce_q;
        result_epoch = epoch_q;
        if (resultValid) begin
            if (newBlock) begin
                result_nonce = '0;
                result_epoch = ~epoch_q;
                next_nonce_d = NONCEBITS'(1);
                epoch_d      = ~epoch_q;
            end else begin
                next_nonce_d = next_nonce_q + NONCEBITS'(1);
            end
        end
    end

    // A pop frees the slot, so a full buffer still accepts a same-cycle winner.
    always_comb begin
        win        = resultValid & success;
        pop        = rdReq & ~fifo_empty;
        push       = win & (~fifo_full | pop);
        drop       = win & fifo_full & ~pop;
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clrOverflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_nonce_q <= '0;
            epoch_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            next_nonce_q <= next_nonce_d;
            epoch_q      <= epoch_d;
            overflow_q   <= overflow_d;
        end
    end

    nonce_fifo #(
        .LogDepth (LOGDEPTH),
        .Width    (NONCEBITS + 1)
    ) u_fifo (
        .clk_i    (clk),
        .rst_ni   (rst),
        .push_i   (push),
        .wdata_i  ({result_nonce, result_epoch}),
        .pop_i    (pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (count)
    );

    assign rdValid  = ~fifo_empty;
    assign rdNonce  = fifo_rdata[NONCEBITS:1];
    assign rdEpoch  = fifo_rdata[0];
    assign overflow = overflow_q;

endmodule

// File: tb/tb_nonce_collector.sv
// Bench for nonce_collector: queue-based model checked every cycle, plus
// literal expectations; a 4-bit-nonce instance covers the counter wrap.
module tb_nonce_collector;

    localparam int Depth = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        resultValid, newBlock, success, rdReq, clrOverflow;
    logic        rdValid, rdEpoch, overflow;
    logic [31:0] rdNonce;
    logic [3:0]  count;

    logic        w_resultValid, w_success, w_rdReq;
    logic        w_rdValid, w_rdEpoch, w_overflow;
    logic [3:0]  w_rdNonce;
    logic [3:0]  w_count;

    int vectors     = 0;
    int miscompares = 0;
    bit run_cmp     = 1'b0;

    nonce_collector dut (
        .clk         (clk),
        .rst         (rst),
        .resultValid (resultValid),
        .newBlock    (newBlock),
        .success     (success),
        .rdReq       (rdReq),
        .clrOverflow (clrOverflow),
        .rdValid     (rdValid),
        .rdNonce     (rdNonce),
        .rdEpoch     (rdEpoch),
        .count       (count),
        .overflow    (overflow)
    );

    nonce_collector #(
        .LOGDEPTH  (3),
        .NONCEBITS (4)
    ) dut_w (
        .clk         (clk),
        .rst         (rst),
        .resultValid (w_resultValid),
        .newBlock    (1'b0),
        .success     (w_success),
        .rdReq       (w_rdReq),
        .clrOverflow (1'b0),
        .rdValid     (w_rdValid),
        .rdNonce     (w_rdNonce),
        .rdEpoch     (w_rdEpoch),
        .count       (w_count),
        .overflow    (w_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of {nonce, epoch}, a nonce counter, an epoch bit, a sticky flag.
    typedef struct {
        logic [31:0] n;
        logic        e;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_next;
    logic        m_epoch, m_ovf;
    logic [31:0] mn;
    logic        me, mpop, mdrop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_next  <= '0;
            m_epoch <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            mn = m_next;
            me = m_epoch;
            if (resultValid) begin
                if (newBlock) begin
                    mn = 32'd0;
                    me = ~m_epoch;
                    m_next  <= 32'd1;
                    m_epoch <= me;
                end else begin
                    m_next <= m_next + 32'd1;
                end
            end
            mpop  = rdReq && (mq.size() > 0);
            mdrop = resultValid && success && (mq.size() == Depth) && !mpop;
            if (mpop) void'(mq.pop_front());
            if (resultValid && success && !mdrop) mq.push_back('{n: mn, e: me});
            if (mdrop) m_ovf <= 1'b1;
            else if (clrOverflow) m_ovf <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp && rst === 1'b1) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("rdValid", 64'(rdValid), 64'(mq.size() != 0));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            if (mq.size() != 0) begin
                chk("rdNonce", 64'(rdNonce), 64'(mq[0].n));
                chk("rdEpoch", 64'(rdEpoch), 64'(mq[0].e));
            end else begin
                chk("rdNonce_empty", 64'(rdNonce), 64'd0);
                chk("rdEpoch_empty", 64'(rdEpoch), 64'd0);
            end
        end
    end

    // One-cycle pulse on the main instance's inputs.
    task automatic step(input logic rv, input logic nb, input logic sc, input logic rr,
                        input logic co);
        @(negedge clk);
        resultValid = rv; newBlock = nb; success = sc; rdReq = rr; clrOverflow = co;
        @(posedge clk);
        #1;
        resultValid = 0; newBlock = 0; success = 0; rdReq = 0; clrOverflow = 0;
    endtask

    task automatic wstep(input logic rv, input logic sc, input logic rr);
        @(negedge clk);
        w_resultValid = rv; w_success = sc; w_rdReq = rr;
        @(posedge clk);
        #1;
        w_resultValid = 0; w_success = 0; w_rdReq = 0;
    endtask

    initial begin
        rst = 1'b0;
        resultValid = 0; newBlock = 0; success = 0; rdReq = 0; clrOverflow = 0;
        w_resultValid = 0; w_success = 0; w_rdReq = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rdValid", 64'(rdValid), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_rdNonce", 64'(rdNonce), 64'd0);
        chk("reset_rdEpoch", 64'(rdEpoch), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_cmp = 1'b1;

        // Five results, newBlock on the first, success on the third.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("first_rdValid", 64'(rdValid), 64'd1);
        chk("first_rdNonce", 64'(rdNonce), 64'd2);
        chk("first_rdEpoch", 64'(rdEpoch), 64'd1);
        chk("first_count", 64'(count), 64'd1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("empty_pop_count", 64'(count), 64'd0);

        // Nine winners from a fresh block; the ninth is dropped.
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_overflow", 64'(overflow), 64'd1);
        chk("full_head", 64'(rdNonce), 64'd0);
        step(1, 0, 1, 0, 1);
        chk("clr_and_drop", 64'(overflow), 64'd1);
        step(0, 0, 0, 0, 1);
        chk("clr_overflow", 64'(overflow), 64'd0);

        // Full with simultaneous pop and push.
        step(1, 0, 1, 1, 0);
        chk("fullpp_count", 64'(count), 64'd8);
        chk("fullpp_overflow", 64'(overflow), 64'd0);
        chk("fullpp_head", 64'(rdNonce), 64'd1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
        chk("tail_nonce", 64'(rdNonce), 64'ha);
        step(0, 0, 0, 1, 0);
        chk("drained", 64'(rdValid), 64'd0);

        // Older-epoch entries survive a newBlock and are read first.
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("epoch_head_nonce", 64'(rdNonce), 64'd0);
        chk("epoch_head_epoch", 64'(rdEpoch), 64'd1);
        chk("epoch_count", 64'(count), 64'd3);
        step(0, 0, 0, 1, 0);
        chk("epoch_second", 64'(rdNonce), 64'd1);
        step(0, 0, 0, 1, 0);
        chk("epoch_new_nonce", 64'(rdNonce), 64'd0);
        chk("epoch_new_epoch", 64'(rdEpoch), 64'd0);

        // Mid-stream reset with four entries buffered.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        chk("pre_reset_count", 64'(count), 64'd4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_rdValid", 64'(rdValid), 64'd0);
        chk("midreset_rdNonce", 64'(rdNonce), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        // Push and rdReq together on an empty buffer: push only.
        step(1, 0, 1, 1, 0);
        chk("post_reset_nonce", 64'(rdNonce), 64'd0);
        chk("post_reset_epoch", 64'(rdEpoch), 64'd0);
        chk("post_reset_count", 64'(count), 64'd1);
        step(0, 0, 0, 1, 0);

        // Counter wrap on the narrow instance: all-ones then zero.
        for (int i = 0; i < 15; i++) wstep(1, 0, 0);
        wstep(1, 1, 0);
        wstep(1, 1, 0);
        chk("wrap_count", 64'(w_count), 64'd2);
        chk("wrap_first", 64'(w_rdNonce), 64'hf);
        chk("wrap_epoch", 64'(w_rdEpoch), 64'd0);
        wstep(0, 0, 1);
        chk("wrap_second", 64'(w_rdNonce), 64'd0);
        wstep(0, 0, 1);
        chk("wrap_empty", 64'(w_rdValid), 64'd0);
        chk("wrap_overflow", 64'(w_overflow), 64'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
